arinc_tx_sched: RTL

ARINC_TX_SCHED -- requirements
Module: arinc_tx_sched

---
 rtl/arinc_pkg.sv | 63 ++++++
 rtl/arinc_tx_sched_if.sv | 25 ++
 rtl/arinc_bit_timer.sv | 52 +++++
 rtl/arinc_tx_sched.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/arinc_pkg.sv
// Shared definitions for the ARINC-429 style transmit scheduler:
// rate encodings, FSM states, source count and word-building helpers.
package arinc_pkg;

    localparam int NSRC         = 4;
    localparam int GAP_BITS_DEF = 4;
    localparam int ADR_W        = 8;
    localparam int DAT_W        = 23;
    localparam int VEL_W        = 2;

    // Index of the final half-bit of a 32-bit word (64 half-bits).
    localparam logic [5:0] LAST_HALF = 6'd63;

    typedef enum logic [1:0] {
        VEL_12K5_A = 2'b00,
        VEL_50K    = 2'b01,
        VEL_100K   = 2'b10,
        VEL_12K5_B = 2'b11
    } vel_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_SEND = 2'b01,
        ST_GAP  = 2'b10
    } state_e;

    // Lay out the word in transmit order: bit k of the result is the k-th bit
    // on the line. Label goes MSB first, data LSB first, odd parity last.
    function automatic logic [31:0] build_word(input logic [ADR_W-1:0] adr,
                                               input logic [DAT_W-1:0] dat);
        logic [31:0] w;
        w = 32'h0000_0000;
        for (int k = 0; k < ADR_W; k++) begin
            w[k] = adr[ADR_W-1-k];
        end
        for (int j = 0; j < DAT_W; j++) begin
            w[ADR_W+j] = dat[j];
        end
        w[31] = ~^{adr, dat};
        return w;
    endfunction

    // Round-robin pick: search starts one past the last granted source.
    function automatic logic [1:0] rr_pick(input logic [NSRC-1:0] req,
                                           input logic [1:0]      last);
        logic [1:0] idx;
        logic [1:0] pick;
        logic       found;
        pick  = 2'd0;
        found = 1'b0;
        for (int i = 1; i <= NSRC; i++) begin
            idx = last + i[1:0];
            if (!found && req[idx]) begin
                pick  = idx;
                found = 1'b1;
            end else begin
                found = found;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/arinc_tx_sched_if.sv
// Source-side request/data bus and serial line outputs of the scheduler.
interface arinc_tx_sched_if;
    import arinc_pkg::*;

    logic [NSRC-1:0]       req;
    logic [ADR_W*NSRC-1:0] adr_in;
    logic [DAT_W*NSRC-1:0] dat_in;
    logic [VEL_W*NSRC-1:0] vel_in;
    logic [NSRC-1:0]       gnt;
    logic                  tx_hi;
    logic                  tx_lo;
    logic                  busy;
    logic                  word_done;

    modport master (
        output req, adr_in, dat_in, vel_in,
        input  gnt, tx_hi, tx_lo, busy, word_done
    );

    modport slave (
        input  req, adr_in, dat_in, vel_in,
        output gnt, tx_hi, tx_lo, busy, word_done
    );

endinterface

// File: rtl/arinc_bit_timer.sv
// Half-bit tick generator: counts clock cycles for the selected line rate
// while the scheduler is sending or holding the inter-word gap.
module arinc_bit_timer
    import arinc_pkg::*;
#(
    parameter int HALF_BIT_100K = 250
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run,
    input  logic [VEL_W-1:0] vel,
    output logic             tick
);

    localparam int CNT_W = 16;

    // The slowest rate is 8x the base half-bit; it must fit the counter.
    if (HALF_BIT_100K < 1 || 8 * HALF_BIT_100K > 65535) begin : g_len_range_err
        $error("arinc_bit_timer: HALF_BIT_100K out of range for 16-bit counter");
    end

    localparam logic [CNT_W-1:0] LEN_100K = CNT_W'(HALF_BIT_100K);
    localparam logic [CNT_W-1:0] LEN_50K  = CNT_W'(2 * HALF_BIT_100K);
    localparam logic [CNT_W-1:0] LEN_12K5 = CNT_W'(8 * HALF_BIT_100K);

    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] half_len_s;

    // Half-bit length in cycles for the captured rate select.
    always_comb begin
        half_len_s = LEN_12K5;
        case (vel_e'(vel))
            VEL_100K: half_len_s = LEN_100K;
            VEL_50K:  half_len_s = LEN_50K;
            default:  half_len_s = LEN_12K5;
        endcase
    end

    assign tick = run && (cnt_r == (half_len_s - 16'd1));

    // Cycle counter within the current half-bit; idles at zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r <= 16'd0;
        end else if (!run || tick) begin
            cnt_r <= 16'd0;
        end else begin
            cnt_r <= cnt_r + 16'd1;
        end
    end

endmodule

// File: rtl/arinc_tx_sched.sv
// Four-source round-robin ARINC word scheduler with RZ line encoding.
// A word is captured at the arbitration edge, so sources may change their
// inputs freely once granted.
module arinc_tx_sched
    import arinc_pkg::*;
#(
    parameter int HALF_BIT_100K = 250,
    parameter int GAP_BITS      = GAP_BITS_DEF
) (
    input  logic            clk,
    input  logic            rst,
    arinc_tx_sched_if.slave bus
);

    if (GAP_BITS < 1 || 2 * GAP_BITS > 65535) begin : g_gap_range_err
        $error("arinc_tx_sched: GAP_BITS out of range");
    end

    localparam logic [15:0] GAP_HALVES = 16'(2 * GAP_BITS);

    state_e           state_r, state_nxt_s;
    logic [5:0]       hb_cnt_r, hb_cnt_nxt_s;
    logic [15:0]      gap_cnt_r, gap_cnt_nxt_s;
    logic [31:0]      word_r, word_nxt_s;
    logic [VEL_W-1:0] vel_r, vel_nxt_s;
    logic [1:0]       last_r, last_nxt_s;
    logic [NSRC-1:0]  gnt_r, gnt_nxt_s;
    logic             tx_hi_r, tx_hi_nxt_s;
    logic             tx_lo_r, tx_lo_nxt_s;
    logic             busy_r, busy_nxt_s;
    logic             word_done_r, word_done_nxt_s;

    logic             run_s;
    logic             tick_s;
    logic [1:0]       pick_s;
    logic [6:0]       dat_base_s;
    logic [ADR_W-1:0] adr_sel_s;
    logic [DAT_W-1:0] dat_sel_s;
    logic [VEL_W-1:0] vel_sel_s;
    logic [31:0]      cap_word_s;
    logic [4:0]       bit_idx_s;
    logic             next_bit_s;

    assign run_s = (state_r != ST_IDLE);

    arinc_bit_timer #(
        .HALF_BIT_100K (HALF_BIT_100K)
    ) u_bit_timer (
        .clk  (clk),
        .rst  (rst),
        .run  (run_s),
        .vel  (vel_r),
        .tick (tick_s)
    );

    // Arbitration winner and its word as it would be captured this edge.
    always_comb begin
        pick_s     = rr_pick(bus.req, last_r);
        dat_base_s = 7'(pick_s) * 7'd23;
        adr_sel_s  = bus.adr_in[{pick_s, 3'b000} +: ADR_W];
        dat_sel_s  = bus.dat_in[dat_base_s +: DAT_W];
        vel_sel_s  = bus.vel_in[{pick_s, 1'b0} +: VEL_W];
        cap_word_s = build_word(adr_sel_s, dat_sel_s);
    end

    // Bit that starts with the next half-bit (only used on odd half-bits).
    assign bit_idx_s  = hb_cnt_r[5:1] + 5'd1;
    assign next_bit_s = word_r[bit_idx_s];

    // Next-state and next-output logic; every output is registered below.
    always_comb begin
        state_nxt_s     = state_r;
        hb_cnt_nxt_s    = hb_cnt_r;
        gap_cnt_nxt_s   = gap_cnt_r;
        word_nxt_s      = word_r;
        vel_nxt_s       = vel_r;
        last_nxt_s      = last_r;
        gnt_nxt_s       = 4'b0000;
        word_done_nxt_s = 1'b0;
        tx_hi_nxt_s     = tx_hi_r;
        tx_lo_nxt_s     = tx_lo_r;
        busy_nxt_s      = busy_r;
        case (state_r)
            ST_IDLE: begin
                if (|bus.req) begin
                    state_nxt_s   = ST_SEND;
                    gnt_nxt_s     = 4'b0001 << pick_s;
                    last_nxt_s    = pick_s;
                    word_nxt_s    = cap_word_s;
                    vel_nxt_s     = vel_sel_s;
                    hb_cnt_nxt_s  = 6'd0;
                    gap_cnt_nxt_s = 16'd0;
                    tx_hi_nxt_s   = cap_word_s[0];
                    tx_lo_nxt_s   = ~cap_word_s[0];
                    busy_nxt_s    = 1'b1;
                end else begin
                    tx_hi_nxt_s = 1'b0;
                    tx_lo_nxt_s = 1'b0;
                    busy_nxt_s  = 1'b0;
                end
            end
            ST_SEND: begin
                if (tick_s) begin
                    if (hb_cnt_r == LAST_HALF) begin
                        state_nxt_s     = ST_GAP;
                        word_done_nxt_s = 1'b1;
                        hb_cnt_nxt_s    = 6'd0;
                        gap_cnt_nxt_s   = 16'd0;
                        tx_hi_nxt_s     = 1'b0;
                        tx_lo_nxt_s     = 1'b0;
                    end else begin
                        hb_cnt_nxt_s = hb_cnt_r + 6'd1;
                        if (hb_cnt_r[0]) begin
                            tx_hi_nxt_s = next_bit_s;
                            tx_lo_nxt_s = ~next_bit_s;
                        end else begin
                            tx_hi_nxt_s = 1'b0;
                            tx_lo_nxt_s = 1'b0;
                        end
                    end
                end else begin
                    hb_cnt_nxt_s = hb_cnt_r;
                end
            end
            ST_GAP: begin
                tx_hi_nxt_s = 1'b0;
                tx_lo_nxt_s = 1'b0;
                if (tick_s) begin
                    if (gap_cnt_r == (GAP_HALVES - 16'd1)) begin
                        state_nxt_s   = ST_IDLE;
                        gap_cnt_nxt_s = 16'd0;
                        busy_nxt_s    = 1'b0;
                    end else begin
                        gap_cnt_nxt_s = gap_cnt_r + 16'd1;
                    end
                end else begin
                    gap_cnt_nxt_s = gap_cnt_r;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
                tx_hi_nxt_s = 1'b0;
                tx_lo_nxt_s = 1'b0;
                busy_nxt_s  = 1'b0;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Datapath, counters and registered outputs; reset leaves source 0 first.
    always_ff @(posedge clk) begin
        if (rst) begin
            hb_cnt_r    <= 6'd0;
            gap_cnt_r   <= 16'd0;
            word_r      <= 32'h0000_0000;
            vel_r       <= 2'b00;
            last_r      <= 2'd3;
            gnt_r       <= 4'b0000;
            tx_hi_r     <= 1'b0;
            tx_lo_r     <= 1'b0;
            busy_r      <= 1'b0;
            word_done_r <= 1'b0;
        end else begin
            hb_cnt_r    <= hb_cnt_nxt_s;
            gap_cnt_r   <= gap_cnt_nxt_s;
            word_r      <= word_nxt_s;
            vel_r       <= vel_nxt_s;
            last_r      <= last_nxt_s;
            gnt_r       <= gnt_nxt_s;
            tx_hi_r     <= tx_hi_nxt_s;
            tx_lo_r     <= tx_lo_nxt_s;
            busy_r      <= busy_nxt_s;
            word_done_r <= word_done_nxt_s;
        end
    end

    assign bus.gnt       = gnt_r;
    assign bus.tx_hi     = tx_hi_r;
    assign bus.tx_lo     = tx_lo_r;
    assign bus.busy      = busy_r;
    assign bus.word_done = word_done_r;

endmodule
